// File: rtl/anim_pkg.sv
// Shared types and sheet geometry for the sprite animation sequencer.
// Channel count, frames per sheet and period width are fixed here for the whole slice.
package anim_pkg;

  localparam int NUM_CHANNELS = 8;
  localparam int NUM_FRAMES   = 5;
  localparam int PERIOD_W     = 4;
  localparam int FW           = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
  localparam int CW           = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  typedef enum logic [1:0] {
    MODE_HOLD     = 2'd0,
    MODE_LOOP     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_ONESHOT  = 2'd3
  } anim_mode_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } seq_state_t;

  localparam logic DIR_FWD  = 1'b0;
  localparam logic DIR_BACK = 1'b1;

  localparam logic [FW-1:0] LAST_FRAME = FW'(NUM_FRAMES - 1);

  typedef struct packed {
    logic [FW-1:0]       frame;
    logic [PERIOD_W-1:0] tick;
    logic                dir;
    anim_mode_t          mode;
    logic [PERIOD_W-1:0] period;
    logic                done;
  } chan_rec_t;

  localparam chan_rec_t REC_RESET = '{
    frame:  '0,
    tick:   '0,
    dir:    DIR_FWD,
    mode:   MODE_HOLD,
    period: PERIOD_W'(1),
    done:   1'b0
  };

  // A fresh configuration restarts the channel; out-of-sheet start frames clamp to 0.
  function automatic chan_rec_t rec_config(input logic [1:0]          mode,
                                           input logic [PERIOD_W-1:0] period,
                                           input logic [FW-1:0]       start);
    chan_rec_t r;
    r        = REC_RESET;
    r.mode   = anim_mode_t'(mode);
    r.period = period;
    r.frame  = (int'(start) >= NUM_FRAMES) ? '0 : start;
    return r;
  endfunction

endpackage

// File: rtl/sprite_anim_seq_if.sv
// Configuration write channel into the sprite animation sequencer.
interface sprite_anim_seq_if
  import anim_pkg::*;
();

  logic                cfg_valid;
  logic                cfg_ready;
  logic [CW-1:0]       cfg_ch;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [FW-1:0]       cfg_start;

  modport master (
    output cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_start,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_mode, cfg_period, cfg_start,
    output cfg_ready
  );

endinterface

// File: rtl/anim_step.sv
// Next-state function for one animation channel: advances the tick and, on period
// expiry, moves the frame according to the channel mode.
module anim_step
  import anim_pkg::*;
(
  input  chan_rec_t rec_i,
  output chan_rec_t rec_o
);

  logic [PERIOD_W-1:0] last_tick;
  logic                active;

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    rec_o     = rec_i;
    last_tick = (rec_i.period == '0) ? '0 : rec_i.period - 1'b1;
    active    = (rec_i.mode != MODE_HOLD) &&
                !((rec_i.mode == MODE_ONESHOT) && rec_i.done);

    if (active) begin
      if (rec_i.tick != last_tick) begin
        rec_o.tick = rec_i.tick + 1'b1;
      end else begin
        rec_o.tick = '0;
        case (rec_i.mode)
          MODE_LOOP: begin
            rec_o.frame = (rec_i.frame == LAST_FRAME) ? '0 : rec_i.frame + 1'b1;
          end
          MODE_PINGPONG: begin
            if (NUM_FRAMES == 1) begin
              rec_o.frame = '0;
            end else if (rec_i.dir == DIR_FWD) begin
              if (rec_i.frame == LAST_FRAME) begin
                rec_o.dir   = DIR_BACK;
                rec_o.frame = rec_i.frame - 1'b1;
              end else begin
                rec_o.frame = rec_i.frame + 1'b1;
              end
            end else begin
              if (rec_i.frame == '0) begin
                rec_o.dir   = DIR_FWD;
                rec_o.frame = rec_i.frame + 1'b1;
              end else begin
                rec_o.frame = rec_i.frame - 1'b1;
              end
            end
          end
          MODE_ONESHOT: begin
            if (rec_i.frame < LAST_FRAME) begin
              rec_o.frame = rec_i.frame + 1'b1;
              rec_o.done  = (rec_i.frame == LAST_FRAME - 1'b1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sprite_anim_seq.sv
// Multi-channel sprite animation sequencer: after each new_frame it sweeps the
// channel records one per clock through a single shared anim_step.
module sprite_anim_seq
  import anim_pkg::*;
(
  input  logic                         clk_pixel_in,
  input  logic                         rst_in_n,
  input  logic                         new_frame,
  sprite_anim_seq_if.slave             cfg,
  output logic [NUM_CHANNELS*FW-1:0]   frame_out,
  output logic [NUM_CHANNELS-1:0]      done_out,
  output logic                         update_done,
  output logic                         overrun
);

  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CHANNELS - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] ch_q, ch_d;
  chan_rec_t     recs_q [NUM_CHANNELS];
  chan_rec_t     step_rec;
  logic          update_done_q, overrun_q;
  logic          cfg_accept, sweep_en;
  logic          last_ch;

  assign last_ch = (ch_q == LAST_CH);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_pixel_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    case (state_q)
      ST_IDLE: begin
        if (new_frame) begin
          state_d = ST_SWEEP;
          ch_d    = '0;
        end
      end
      ST_SWEEP: begin
        if (last_ch) state_d = ST_IDLE;
        else         ch_d    = ch_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // new_frame wins over a config write arriving in the same IDLE cycle.
  always_comb begin
    cfg.cfg_ready = (state_q == ST_IDLE) && !new_frame;
    cfg_accept    = cfg.cfg_valid && cfg.cfg_ready && (int'(cfg.cfg_ch) < NUM_CHANNELS);
    sweep_en      = (state_q == ST_SWEEP);
  end

  anim_step u_step (
    .rec_i (recs_q[ch_q]),
    .rec_o (step_rec)
  );

  // NOTE: the record array is reset in full because frame_out exposes every entry in parallel.
  always_ff @(posedge clk_pixel_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) recs_q[k] <= REC_RESET;
    end else if (cfg_accept) begin
      recs_q[cfg.cfg_ch] <= rec_config(cfg.cfg_mode, cfg.cfg_period, cfg.cfg_start);
    end else if (sweep_en) begin
      recs_q[ch_q] <= step_rec;
    end
  end

  // Overrun is sticky; a frame pulse that lands mid-sweep is dropped, not queued.
  always_ff @(posedge clk_pixel_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      update_done_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      update_done_q <= sweep_en && last_ch;
      if (sweep_en && new_frame) overrun_q <= 1'b1;
    end
  end

  always_comb begin
    frame_out = '0;
    done_out  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      frame_out[k*FW +: FW] = recs_q[k].frame;
      done_out[k]           = recs_q[k].done;
    end
  end

  assign update_done = update_done_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_sprite_anim_seq.sv
// Scoreboard bench for sprite_anim_seq: each frame pulse queues the hand-derived
// per-channel frames, and a monitor checks them when update_done fires.
module tb_sprite_anim_seq;
  import anim_pkg::*;

  logic                       clk_pixel_in;
  logic                       rst_in_n;
  logic                       new_frame;
  logic [NUM_CHANNELS*FW-1:0] frame_out;
  logic [NUM_CHANNELS-1:0]    done_out;
  logic                       update_done;
  logic                       overrun;

  sprite_anim_seq_if cfg_if ();

  sprite_anim_seq dut (
    .clk_pixel_in (clk_pixel_in),
    .rst_in_n     (rst_in_n),
    .new_frame    (new_frame),
    .cfg          (cfg_if),
    .frame_out    (frame_out),
    .done_out     (done_out),
    .update_done  (update_done),
    .overrun      (overrun)
  );

  initial begin
    clk_pixel_in = 1'b0;
    forever #5 clk_pixel_in = ~clk_pixel_in;
  end

  int cyc = 0;
  always @(posedge clk_pixel_in) cyc <= cyc + 1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  // Frame after the k-th pulse for channels 0..4 (channels 5..7 stay at 0).
  // ch0 LOOP p2 s0, ch1 PINGPONG p1 s3, ch2 ONESHOT p1 s2 then s0 after pulse 5,
  // ch3 LOOP p0 s0, ch4 HOLD s2 (the colliding write at pulse 13 is ignored).
  int exp_tab [5][14] = '{
    '{0, 1, 1, 2, 2, 3, 3, 4, 4, 0, 0, 1, 1, 2},
    '{4, 3, 2, 1, 0, 1, 2, 3, 4, 3, 2, 1, 0, 1},
    '{3, 4, 4, 4, 4, 1, 2, 3, 4, 4, 4, 4, 4, 4},
    '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2, 3, 4},
    '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2}
  };
  int exp_done2 [14] = '{0, 1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};

  typedef struct {
    logic [NUM_CHANNELS*FW-1:0] frames;
    logic [NUM_CHANNELS-1:0]    done;
    int                         cyc;
  } sb_entry_t;

  sb_entry_t sb_q [$];

  // Called in the negedge before the edge that samples new_frame.
  task automatic push_exp(input int k);
    sb_entry_t e;
    e.frames = '0;
    for (int c = 0; c < 5; c++) e.frames[c*FW +: FW] = FW'(exp_tab[c][k-1]);
    e.done    = '0;
    e.done[2] = exp_done2[k-1][0];
    e.cyc     = cyc + 1 + NUM_CHANNELS;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_pixel_in) begin
    if (rst_in_n && update_done) begin
      if (sb_q.size() == 0) begin
        check("spurious_update_done", 64'(update_done), 64'd0);
      end else begin
        sb_entry_t e;
        e = sb_q.pop_front();
        check("update_done_cycle", 64'(cyc), 64'(e.cyc));
        check("sweep_frames", 64'(frame_out), 64'(e.frames));
        check("sweep_done", 64'(done_out), 64'(e.done));
      end
    end
  end

  task automatic cfg_write(input int ch, input int mode, input int period, input int start);
    @(negedge clk_pixel_in);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CW'(ch);
    cfg_if.cfg_mode   = 2'(mode);
    cfg_if.cfg_period = PERIOD_W'(period);
    cfg_if.cfg_start  = FW'(start);
    #1 check("cfg_ready_idle", 64'(cfg_if.cfg_ready), 64'd1);
    @(negedge clk_pixel_in);
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic pulse_frame(input int k);
    @(negedge clk_pixel_in);
    new_frame = 1'b1;
    push_exp(k);
    @(negedge clk_pixel_in);
    new_frame = 1'b0;
    repeat (12) @(negedge clk_pixel_in);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk_pixel_in);
      n++;
    end
    check("scoreboard_drain", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rst_in_n          = 1'b0;
    new_frame         = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_mode   = '0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_start  = '0;
    repeat (3) @(negedge clk_pixel_in);
    rst_in_n = 1'b1;
    @(negedge clk_pixel_in);

    check("rst_frame_out", 64'(frame_out), 64'd0);
    check("rst_done_out", 64'(done_out), 64'd0);
    check("rst_update_done", 64'(update_done), 64'd0);
    check("rst_overrun", 64'(overrun), 64'd0);
    check("rst_cfg_ready", 64'(cfg_if.cfg_ready), 64'd1);

    cfg_write(0, 1, 2, 0);
    cfg_write(1, 2, 1, 3);
    cfg_write(2, 3, 1, 2);
    cfg_write(3, 1, 0, 0);
    cfg_write(4, 0, 5, 2);
    check("cfg_ch1_frame", 64'(frame_out[1*FW +: FW]), 64'd3);
    check("cfg_ch2_frame", 64'(frame_out[2*FW +: FW]), 64'd2);
    check("cfg_ch4_frame", 64'(frame_out[4*FW +: FW]), 64'd2);

    for (int k = 1; k <= 5; k++) pulse_frame(k);
    drain();

    cfg_write(2, 3, 1, 0);
    check("reconfig_ch2_done", 64'(done_out[2]), 64'd0);
    check("reconfig_ch2_frame", 64'(frame_out[2*FW +: FW]), 64'd0);
    cfg_write(5, 0, 1, 7);
    check("cfg_start_clamp", 64'(frame_out[5*FW +: FW]), 64'd0);

    for (int k = 6; k <= 12; k++) pulse_frame(k);
    drain();

    // Config write colliding with new_frame: not accepted, sweep proceeds.
    @(negedge clk_pixel_in);
    new_frame         = 1'b1;
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = CW'(4);
    cfg_if.cfg_mode   = 2'd1;
    cfg_if.cfg_period = PERIOD_W'(1);
    cfg_if.cfg_start  = FW'(0);
    push_exp(13);
    #1 check("collision_cfg_ready", 64'(cfg_if.cfg_ready), 64'd0);
    @(negedge clk_pixel_in);
    new_frame        = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    repeat (12) @(negedge clk_pixel_in);
    drain();

    // Second new_frame three cycles into a sweep is dropped and flags overrun.
    check("pre_overrun", 64'(overrun), 64'd0);
    @(negedge clk_pixel_in);
    new_frame = 1'b1;
    push_exp(14);
    @(negedge clk_pixel_in);
    new_frame = 1'b0;
    repeat (2) @(negedge clk_pixel_in);
    new_frame = 1'b1;
    @(negedge clk_pixel_in);
    new_frame = 1'b0;
    repeat (14) @(negedge clk_pixel_in);
    drain();
    check("overrun_set", 64'(overrun), 64'd1);

    // Asynchronous reset in the middle of a sweep.
    cfg_write(2, 0, 1, 3);
    check("pre_reset_ch2_frame", 64'(frame_out[2*FW +: FW]), 64'd3);
    @(negedge clk_pixel_in);
    new_frame = 1'b1;
    @(negedge clk_pixel_in);
    new_frame = 1'b0;
    repeat (2) @(posedge clk_pixel_in);
    #1 rst_in_n = 1'b0;
    #1;
    check("midreset_frame_out", 64'(frame_out), 64'd0);
    check("midreset_done_out", 64'(done_out), 64'd0);
    check("midreset_update_done", 64'(update_done), 64'd0);
    check("midreset_cfg_ready", 64'(cfg_if.cfg_ready), 64'd1);
    check("midreset_overrun", 64'(overrun), 64'd0);
    @(negedge clk_pixel_in);
    rst_in_n = 1'b1;
    repeat (20) @(negedge clk_pixel_in);
    check("post_reset_frame_out", 64'(frame_out), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
